// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID-stage operand forwarding, load-use detection and ID/EX pipeline register
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_ra0,
  input  logic [ADDR_W-1:0] id_ra1,
  input  logic              id_use0,
  input  logic              id_use1,
  input  logic [DATA_W-1:0] rf_rd0,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [ADDR_W-1:0] id_wa,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic [31:0]       id_pc,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] ex_alu_res,
  input  logic [ADDR_W-1:0] mem_wa,
  input  logic              mem_we,
  input  logic [DATA_W-1:0] mem_wd,
  input  logic [ADDR_W-1:0] wb_wa,
  input  logic              wb_we,
  input  logic [DATA_W-1:0] wb_wd,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              stall_id,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_src0,
  output logic [DATA_W-1:0] ex_src1,
  output logic [ADDR_W-1:0] ex_wa,
  output logic              ex_we,
  output logic              ex_is_load,
  output logic [31:0]       ex_pc,
  output logic [DATA_W-1:0] ex_imm,
  output logic [31:0]       bubble_cnt
);

  logic [DATA_W-1:0] fwd0;
  logic [DATA_W-1:0] fwd1;
  logic              ex_fwd_ok;
  logic              hazard0;
  logic              hazard1;

  // A load in EX has no data yet, so it never forwards; it stalls instead.
  assign ex_fwd_ok = ex_valid & ex_we & ~ex_is_load;

  always_comb begin
    fwd0 = rf_rd0;
    if (id_ra0 == '0)                        fwd0 = '0;
    else if (ex_fwd_ok && ex_wa == id_ra0)   fwd0 = ex_alu_res;
    else if (mem_we && mem_wa == id_ra0)     fwd0 = mem_wd;
    else if (wb_we && wb_wa == id_ra0)       fwd0 = wb_wd;
  end

  always_comb begin
    fwd1 = rf_rd1;
    if (id_ra1 == '0)                        fwd1 = '0;
    else if (ex_fwd_ok && ex_wa == id_ra1)   fwd1 = ex_alu_res;
    else if (mem_we && mem_wa == id_ra1)     fwd1 = mem_wd;
    else if (wb_we && wb_wa == id_ra1)       fwd1 = wb_wd;
  end

  assign hazard0  = id_use0 & (ex_wa == id_ra0);
  assign hazard1  = id_use1 & (ex_wa == id_ra1);
  assign stall_id = ~flush & id_valid & ex_valid & ex_is_load & ex_we &
                    (ex_wa != '0) & (hazard0 | hazard1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_src0    <= '0;
      ex_src1    <= '0;
      ex_wa      <= '0;
      ex_we      <= 1'b0;
      ex_is_load <= 1'b0;
      ex_pc      <= '0;
      ex_imm     <= '0;
      bubble_cnt <= '0;
    end else if (flush) begin
      ex_valid   <= 1'b0;
      ex_we      <= 1'b0;
      ex_is_load <= 1'b0;
    end else if (ex_stall) begin
      ex_valid   <= ex_valid;
    end else if (stall_id) begin
      ex_valid   <= 1'b0;
      ex_we      <= 1'b0;
      ex_is_load <= 1'b0;
      bubble_cnt <= bubble_cnt + 32'd1;
    end else begin
      // Side effects of an empty slot are suppressed so later stages never see a write.
      ex_valid   <= id_valid;
      ex_src0    <= fwd0;
      ex_src1    <= fwd1;
      ex_wa      <= id_wa;
      ex_we      <= id_valid & id_we;
      ex_is_load <= id_valid & id_is_load;
      ex_pc      <= id_pc;
      ex_imm     <= id_imm;
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - directed-vector bench for id_ex_operand_stage
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use0, id_use1, id_we, id_is_load;
  logic [4:0]  id_ra0, id_ra1, id_wa, mem_wa, wb_wa;
  logic [31:0] rf_rd0, rf_rd1, id_pc, id_imm, ex_alu_res, mem_wd, wb_wd;
  logic        mem_we, wb_we, flush, ex_stall;
  logic        stall_id, ex_valid, ex_we, ex_is_load;
  logic [31:0] ex_src0, ex_src1, ex_pc, ex_imm, bubble_cnt;
  logic [4:0]  ex_wa;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra0(id_ra0), .id_ra1(id_ra1),
    .id_use0(id_use0), .id_use1(id_use1), .rf_rd0(rf_rd0), .rf_rd1(rf_rd1),
    .id_wa(id_wa), .id_we(id_we), .id_is_load(id_is_load), .id_pc(id_pc),
    .id_imm(id_imm), .ex_alu_res(ex_alu_res), .mem_wa(mem_wa), .mem_we(mem_we),
    .mem_wd(mem_wd), .wb_wa(wb_wa), .wb_we(wb_we), .wb_wd(wb_wd), .flush(flush),
    .ex_stall(ex_stall), .stall_id(stall_id), .ex_valid(ex_valid),
    .ex_src0(ex_src0), .ex_src1(ex_src1), .ex_wa(ex_wa), .ex_we(ex_we),
    .ex_is_load(ex_is_load), .ex_pc(ex_pc), .ex_imm(ex_imm), .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_use0 = 0; id_use1 = 0; id_we = 0; id_is_load = 0;
    id_ra0 = 0; id_ra1 = 0; id_wa = 0; rf_rd0 = 0; rf_rd1 = 0;
    id_pc = 0; id_imm = 0; ex_alu_res = 0; mem_wa = 0; mem_we = 0; mem_wd = 0;
    wb_wa = 0; wb_we = 0; wb_wd = 0; flush = 0; ex_stall = 0;
  endtask

  task automatic issue_load(input logic [4:0] wa);
    id_valid = 1; id_is_load = 1; id_we = 1; id_wa = wa;
    id_use0 = 0; id_use1 = 0; id_ra0 = 0; id_ra1 = 0;
    step();
    id_is_load = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      id_valid = 1; id_we = 1; id_is_load = $urandom_range(0, 1);
      id_ra0 = 5'($urandom); id_ra1 = 5'($urandom); id_wa = 5'($urandom);
      rf_rd0 = $urandom; rf_rd1 = $urandom; id_pc = $urandom; id_imm = $urandom;
      id_use0 = 1; id_use1 = 1;
      step();
    end
    chk("rst_valid", 32'(ex_valid), 0);
    chk("rst_src0", ex_src0, 0);
    chk("rst_src1", ex_src1, 0);
    chk("rst_wa", 32'(ex_wa), 0);
    chk("rst_we", 32'(ex_we), 0);
    chk("rst_load", 32'(ex_is_load), 0);
    chk("rst_pc", ex_pc, 0);
    chk("rst_imm", ex_imm, 0);
    chk("rst_bcnt", bubble_cnt, 0);
    chk("rst_stall", 32'(stall_id), 0);
    rst = 0;
    idle_inputs();

    // plain register-file operands
    id_valid = 1; id_ra0 = 1; id_ra1 = 2; rf_rd0 = 32'h1000_0000; rf_rd1 = 5;
    id_wa = 7; id_we = 1; id_pc = 32'h100; id_imm = 32'h44; id_use0 = 1; id_use1 = 1;
    step();
    chk("nohaz_src0", ex_src0, 32'h1000_0000);
    chk("nohaz_src1", ex_src1, 5);
    chk("nohaz_valid", 32'(ex_valid), 1);
    chk("nohaz_wa", 32'(ex_wa), 7);
    chk("nohaz_we", 32'(ex_we), 1);
    chk("nohaz_pc", ex_pc, 32'h100);
    chk("nohaz_imm", ex_imm, 32'h44);

    // forwarding priority on x3
    id_wa = 3; id_we = 1;
    step();
    id_ra0 = 3; id_ra1 = 3; id_wa = 9; id_we = 0;
    rf_rd0 = 32'hDDDD; rf_rd1 = 32'hDDDD; ex_alu_res = 32'hAAAA;
    mem_wa = 3; mem_we = 1; mem_wd = 32'hBBBB;
    wb_wa = 3; wb_we = 1; wb_wd = 32'hCCCC;
    step();
    chk("fwd_ex", ex_src0, 32'hAAAA);
    chk("fwd_ex_s1", ex_src1, 32'hAAAA);
    step();
    chk("fwd_mem", ex_src0, 32'hBBBB);
    mem_we = 0;
    step();
    chk("fwd_wb", ex_src0, 32'hCCCC);
    chk("fwd_wb_s1", ex_src1, 32'hCCCC);
    wb_we = 0;
    step();
    chk("fwd_rf", ex_src0, 32'hDDDD);
    id_ra0 = 0; mem_wa = 0; mem_we = 1; wb_wa = 0; wb_we = 1; rf_rd0 = 32'h5555;
    step();
    chk("fwd_x0", ex_src0, 0);
    idle_inputs();

    // load-use: exactly one bubble, then MEM forwarding
    issue_load(5);
    id_ra0 = 5; id_use0 = 1; id_wa = 6; id_we = 1; rf_rd0 = 32'hDEAD;
    #1;
    chk("lu_stall", 32'(stall_id), 1);
    step();
    chk("lu_bubble_valid", 32'(ex_valid), 0);
    chk("lu_bubble_we", 32'(ex_we), 0);
    chk("lu_bcnt", bubble_cnt, 1);
    chk("lu_stall_clear", 32'(stall_id), 0);
    mem_wa = 5; mem_we = 1; mem_wd = 32'h1234;
    step();
    chk("lu_fwd_mem", ex_src0, 32'h1234);
    chk("lu_valid", 32'(ex_valid), 1);
    mem_we = 0;

    // no stall when the matching source is not actually read
    issue_load(5);
    id_ra0 = 5; id_use0 = 0; id_wa = 6;
    #1;
    chk("lu_unused_src", 32'(stall_id), 0);

    // flush suppresses the stall and the bubble count
    issue_load(5);
    id_ra1 = 5; id_use1 = 1; id_wa = 6; flush = 1;
    #1;
    chk("fl_stall", 32'(stall_id), 0);
    step();
    chk("fl_valid", 32'(ex_valid), 0);
    chk("fl_bcnt", bubble_cnt, 1);
    flush = 0;

    // invalid ID slot
    idle_inputs();
    id_valid = 0; id_we = 1; id_wa = 4;
    step();
    chk("inv_valid", 32'(ex_valid), 0);
    chk("inv_we", 32'(ex_we), 0);

    // ex_stall hold for three cycles
    id_valid = 1; id_ra0 = 1; id_use0 = 1; rf_rd0 = 32'h77; id_wa = 8; id_we = 1;
    id_pc = 32'h200; id_imm = 32'h11;
    step();
    ex_stall = 1;
    for (int i = 0; i < 3; i++) begin
      id_pc = 32'h210 + 32'(i); id_imm = 32'h20 + 32'(i); rf_rd0 = 32'h80 + 32'(i);
      step();
      chk("hold_pc", ex_pc, 32'h200);
      chk("hold_src0", ex_src0, 32'h77);
      chk("hold_imm", ex_imm, 32'h11);
    end
    ex_stall = 0; id_pc = 32'h300; rf_rd0 = 32'h99;
    step();
    chk("rel_pc", ex_pc, 32'h300);
    chk("rel_src0", ex_src0, 32'h99);

    // flush beats ex_stall
    ex_stall = 1; flush = 1;
    step();
    chk("fl_over_hold", 32'(ex_valid), 0);
    ex_stall = 0; flush = 0;

    // reset during a load-use stall
    idle_inputs();
    issue_load(5);
    id_ra0 = 5; id_use0 = 1; rst = 1;
    step();
    rst = 0;
    #1;
    chk("rst_mid_valid", 32'(ex_valid), 0);
    chk("rst_mid_stall", 32'(stall_id), 0);
    chk("rst_mid_bcnt", bubble_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Consumes the register file's two read ports (rf_rd0/rf_rd1) in the ID stage of the 5-stage pipelined CPU.
- Resolves RAW hazards by forwarding from the EX, MEM and WB stages.
- Detects load-use hazards and inserts bubbles.
- Registers the resolved operands and control into the ID/EX pipeline register that feeds the ALU.
- Keeps a stall/bubble counter for the debug bus.

Parameters:
DATA_W, 32, operand/data width
ADDR_W, 5, register address width (32 registers, x0 hard-wired zero)

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a valid instruction
id_ra0  in  ADDR_W  source reg 0 address (also drives REG_FILE rf_ra0)
id_ra1  in  ADDR_W  source reg 1 address (also drives REG_FILE rf_ra1)
id_use0  in  1  instruction reads ra0
id_use1  in  1  instruction reads ra1
rf_rd0  in  DATA_W  REG_FILE read data 0
rf_rd1  in  DATA_W  REG_FILE read data 1
id_wa  in  ADDR_W  destination address
id_we  in  1  instruction writes RF
id_is_load  in  1  instruction is a load
id_pc  in  32  instruction PC
id_imm  in  DATA_W  decoded immediate
ex_alu_res  in  DATA_W  EX-stage ALU result (combinational, same cycle)
mem_wa  in  ADDR_W  MEM-stage destination
mem_we  in  1  MEM-stage write enable (valid-qualified)
mem_wd  in  DATA_W  MEM-stage writeback value (load data included)
wb_wa  in  ADDR_W  WB-stage destination
wb_we  in  1  WB-stage write enable (also drives rf_we)
wb_wd  in  DATA_W  WB-stage writeback value (also drives rf_wd)
flush  in  1  branch/jump redirect from EX; kill the ID instruction
ex_stall  in  1  downstream hold request
stall_id  out  1  load-use stall; IF and ID must hold
ex_valid  out  1  ID/EX valid
ex_src0  out  DATA_W  resolved operand 0
ex_src1  out  DATA_W  resolved operand 1
ex_wa  out  ADDR_W  registered destination
ex_we  out  1  registered write enable
ex_is_load  out  1  registered load flag
ex_pc  out  32  registered PC
ex_imm  out  DATA_W  registered immediate
bubble_cnt  out  32  number of bubbles inserted since reset

Behaviour:
- Reset: all ex_* outputs are 0 and bubble_cnt is 0. stall_id is combinational and therefore 0 while ex_valid=0.
- Forwarding is combinational, evaluated per source n (0/1) in strict priority:
  1. ra_n == 0 -> 0.
  2. EX match: ex_valid & ex_we & !ex_is_load & ex_wa == ra_n -> ex_alu_res.
  3. MEM match: mem_we & mem_wa == ra_n -> mem_wd.
  4. WB match: wb_we & wb_wa == ra_n -> wb_wd. REG_FILE writes at the clock edge, so same-cycle WB data must be forwarded.
  5. Otherwise -> rf_rd_n.
- Load-use: stall_id = id_valid & ex_valid & ex_is_load & ex_we & ex_wa != 0 & ((id_use0 & ex_wa == id_ra0) | (id_use1 & ex_wa == id_ra1)). stall_id is forced to 0 when flush=1.
- ID/EX register update at each clock edge, in priority order:
  1. rst -> clear everything.
  2. flush -> ex_valid = 0; ex_we and ex_is_load are also cleared.
  3. ex_stall -> hold all ex_* registers unchanged. stall_id still reflects the current hazard; upstream holds on stall_id | ex_stall.
  4. stall_id -> bubble: ex_valid = 0, ex_we = 0, ex_is_load = 0; bubble_cnt += 1.
  5. Otherwise -> load all ex_* from ID; ex_valid = id_valid; ex_src from forwarding.
- Latency: one cycle from ID inputs to ex_* outputs.
- Load-use penalty: exactly one bubble. The following cycle the load sits in MEM and is forwarded via mem_wd.
- Invalid ID (id_valid=0): ex_valid = 0, ex_we = 0, no bubble counted.
- bubble_cnt wraps from 0xFFFFFFFF to 0.
- Flush and ex_stall asserted together: flush wins.
- Reset mid-stall: pipeline register clears; no stall follows the reset.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> all ex_* = 0, bubble_cnt = 0, stall_id = 0.
- No hazard: ra0=1, ra1=2, rf_rd0=0x10000000, rf_rd1=5, no EX/MEM/WB matches -> next cycle ex_src0 = 0x10000000, ex_src1 = 5, ex_valid = 1.
- Forward priority: ra0=3 with EX ALU writing 3 = 0xAAAA, mem_wa=3 mem_wd=0xBBBB, wb_wa=3 wb_wd=0xCCCC -> ex_src0 = 0xAAAA. Drop the EX match -> 0xBBBB. Drop MEM -> 0xCCCC. With ra0=0 -> 0.
- Load-use: load to x5 in ID/EX, next instruction reads x5 -> stall_id = 1 for one cycle, bubble (ex_valid = 0), bubble_cnt = 1. Next cycle mem_wa=5, mem_wd=0x1234 -> ex_src0 = 0x1234.
- Flush during stall: same load-use setup plus flush=1 -> stall_id = 0, ex_valid = 0, bubble_cnt unchanged.
- ex_stall hold: ex_stall=1 for 3 cycles with changing ID inputs -> ex_* constant. Release -> the current ID instruction loads.
